// File: rtl/prefetch_queue_if.sv
// Bus bundle between the prefetch queue, the memory controller burst port
// and the instruction decoder. Signal names carry the direction as seen
// from the queue: i* flows into the queue, o* flows out of it.
// master: environment side (controller + decoder). slave: the queue.
interface prefetch_queue_if;
  logic [31:0] iData32;
  logic [1:0]  iIndex32;
  logic        iAck32;
  logic        iJumped;
  logic [2:0]  iConsume;
  logic        oMemReq;
  logic [47:0] oBytes;
  logic [2:0]  oValidCnt;
  logic        oEmpty;

  modport master (
    output iData32, iIndex32, iAck32, iJumped, iConsume,
    input  oMemReq, oBytes, oValidCnt, oEmpty
  );

  modport slave (
    input  iData32, iIndex32, iAck32, iJumped, iConsume,
    output oMemReq, oBytes, oValidCnt, oEmpty
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch byte queue.
// Requests 8-beat code bursts from the memory controller, packs the 32-bit
// beats (first beat may start mid-word) into a circular byte FIFO and
// presents a 6-byte window to the decoder, which consumes 0..6 bytes per
// cycle and flushes the queue on a jump.
// Optional build macro PREFETCH_PERF_EN adds saturating flush / discarded
// beat counters on oFlushCnt / oDiscardCnt.
module prefetch_queue #(
  parameter int DEPTH = 64,
  parameter int WIN   = 6
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  prefetch_queue_if.slave      bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]          oFlushCnt,
  output logic [15:0]          oDiscardCnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // A request is only made when a whole 32-byte burst is guaranteed to fit.
  localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(DEPTH - 32);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t             state_q;
  logic [2:0]         beat_q;
  logic [3:0]         discard_q;
  logic               mem_req_q;

  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [8*WIN-1:0]   bytes_q, bytes_d;
  logic [2:0]         valid_cnt_q, valid_d;
  logic               empty_q;

  logic               push_en;
  logic [1:0]         push_idx;
  logic [2:0]         push_n;
  logic [2:0]         pop_n;
  logic [31:0]        push_word;
  logic [PTR_W-1:0]   win_off;

  // Next queue state and the window as it will look after the edge,
  // including bytes written this very cycle (bypass around the memory).
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    push_en   = bus.iAck32 && (state_q == BURST) && !bus.iJumped;
    push_idx  = (beat_q == 3'd0) ? bus.iIndex32 : 2'd0;
    push_n    = push_en ? (3'd4 - {1'b0, push_idx}) : 3'd0;
    push_word = bus.iData32 >> {push_idx, 3'b000};
    pop_n     = (bus.iConsume > valid_cnt_q) ? valid_cnt_q : bus.iConsume;
    rd_d      = rd_q + PTR_W'(pop_n);
    wr_d      = wr_q + PTR_W'(push_n);
    count_d   = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    // A flush wins over any same-cycle push or pop.
    if (bus.iJumped) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
    valid_d = (count_d > CNT_W'(WIN)) ? 3'(WIN) : count_d[2:0];
    bytes_d = '0;
    win_off = '0;
    for (int j = 0; j < WIN; j++) begin
      // Distance of this window slot from the current write pointer: a slot
      // inside the bytes being pushed now is taken from the incoming beat.
      win_off = rd_d + PTR_W'(j) - wr_q;
      if (3'(j) < valid_d) begin
        if (win_off < PTR_W'(push_n)) begin
          bytes_d[8*j +: 8] = push_word[8*win_off[1:0] +: 8];
        end else begin
          bytes_d[8*j +: 8] = mem_q[rd_d + PTR_W'(j)];
        end
      end
    end
  end

  // Byte storage: write the accepted bytes of a beat in ascending order.
  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are meaningful, so clearing it would buy nothing.
  always_ff @(posedge iClk) begin
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < push_n) begin
        mem_q[wr_q + PTR_W'(k)] <= push_word[8*k +: 8];
      end
    end
  end

  // Pointers, fill count and registered decoder-side outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!iRst_n) begin
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      bytes_q     <= '0;
      valid_cnt_q <= '0;
      empty_q     <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      bytes_q     <= bytes_d;
      valid_cnt_q <= valid_d;
      empty_q     <= (count_d == '0);
    end
  end

  // Burst request FSM: request, count beats, discard the tail after a jump.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      discard_q <= '0;
      mem_req_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.iJumped || (count_q <= REQ_LIMIT)) begin
            mem_req_q <= 1'b1;
            beat_q    <= '0;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (bus.iJumped) begin
            mem_req_q <= 1'b1;
            if (bus.iAck32 && (beat_q == 3'd7)) begin
              // Old burst fully received: nothing left to discard.
              beat_q <= '0;
            end else begin
              discard_q <= 4'd8 - {1'b0, beat_q} - {3'd0, bus.iAck32};
              state_q   <= DRAIN;
            end
          end else if (bus.iAck32) begin
            if (beat_q == 3'd7) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (bus.iAck32) begin
            discard_q <= discard_q - 4'd1;
            if (discard_q == 4'd1) begin
              beat_q  <= '0;
              state_q <= BURST;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oMemReq   = mem_req_q;
  assign bus.oBytes    = bytes_q;
  assign bus.oValidCnt = valid_cnt_q;
  assign bus.oEmpty    = empty_q;

`ifdef PREFETCH_PERF_EN
  logic [15:0] flush_cnt_q;
  logic [15:0] discard_cnt_q;
  logic        discard_ev;

  assign discard_ev = bus.iAck32 &&
                      (((state_q == BURST) && bus.iJumped) || (state_q == DRAIN));

  // Saturating event counters for flushes and discarded beats.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      flush_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (bus.iJumped && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if (discard_ev && (discard_cnt_q != 16'hFFFF)) begin
        discard_cnt_q <= discard_cnt_q + 16'd1;
      end
    end
  end

  assign oFlushCnt   = flush_cnt_q;
  assign oDiscardCnt = discard_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_ack_in_idle: assert property (@(posedge iClk) disable iff (!iRst_n)
    !(bus.iAck32 && (state_q == IDLE)))
    else $error("prefetch_queue: beat acknowledged while no burst is outstanding");

  a_consume_le_valid: assert property (@(posedge iClk) disable iff (!iRst_n)
    bus.iConsume <= valid_cnt_q)
    else $error("prefetch_queue: decoder consumed more bytes than are valid");
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus a
// randomized run, all compared against a byte-queue reference model.
module tb_prefetch_queue;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  prefetch_queue_if bus ();

`ifdef PREFETCH_PERF_EN
  logic [15:0] flush_cnt;
  logic [15:0] discard_cnt;
`endif

  prefetch_queue #(.DEPTH(DEPTH), .WIN(6)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
`ifdef PREFETCH_PERF_EN
    ,
    .oFlushCnt   (flush_cnt),
    .oDiscardCnt (discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mq[$];       // bytes currently queued, oldest first
  int  m_mode;             // 0: no burst open, 1: accepting beats, 2: discarding beats
  int  m_beats;            // beats received in the open burst
  int  m_discard;          // stale beats still to be thrown away
  bit  m_req;              // request pulse expected after the last edge
  bit  m_empty;            // expected oEmpty
  int  m_flushes;
  int  m_discards;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_beats = 0; m_discard = 0;
    m_req = 1'b0; m_empty = 1'b0;
    m_flushes = 0; m_discards = 0;
  endtask

  function automatic int exp_valid();
    return (mq.size() > 6) ? 6 : mq.size();
  endfunction

  function automatic logic [47:0] exp_bytes();
    logic [47:0] r = '0;
    for (int i = 0; i < 6 && i < mq.size(); i++) r[8*i +: 8] = mq[i];
    return r;
  endfunction

  task automatic model_step(bit a, logic [1:0] idx, logic [31:0] d, bit j, int c);
    int sz0 = mq.size();
    int v0  = (sz0 > 6) ? 6 : sz0;
    int first;
    m_req = 1'b0;
    if (j) begin
      mq.delete();
      m_flushes++;
    end else begin
      repeat ((c < v0) ? c : v0) void'(mq.pop_front());
    end
    case (m_mode)
      0: if (j || sz0 <= DEPTH - 32) begin m_req = 1'b1; m_mode = 1; m_beats = 0; end
      1: begin
        if (a) begin
          first = (m_beats == 0) ? int'(idx) : 0;
          m_beats++;
          if (j) m_discards++;
          else for (int b = first; b < 4; b++) mq.push_back(d[8*b +: 8]);
        end
        if (j) begin
          m_req = 1'b1;
          if (m_beats == 8) m_beats = 0;
          else begin m_discard = 8 - m_beats; m_mode = 2; end
        end else if (m_beats == 8) begin
          m_mode = 0; m_beats = 0;
        end
      end
      default: if (a) begin
        m_discards++;
        m_discard--;
        if (m_discard == 0) begin m_mode = 1; m_beats = 0; end
      end
    endcase
    m_empty = (mq.size() == 0);
  endtask

  // One clock: drive inputs, take the edge, update the model, settle.
  task automatic cycle(bit a, logic [1:0] idx, logic [31:0] d, bit j, int c);
    bus.iAck32 = a; bus.iIndex32 = idx; bus.iData32 = d;
    bus.iJumped = j; bus.iConsume = 3'(c);
    @(posedge clk);
    model_step(a, idx, d, j, c);
    #1;
    bus.iAck32 = 1'b0; bus.iJumped = 1'b0; bus.iConsume = 3'd0;
  endtask

  task automatic apply_reset();
    bus.iAck32 = 1'b0; bus.iIndex32 = 2'd0; bus.iData32 = '0;
    bus.iJumped = 1'b0; bus.iConsume = 3'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b empty=%0b valid=%0d bytes=%h required all zero",
               bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.oMemReq !== 1'b1 || bus.oEmpty !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_req: got req=%0b empty=%0b required req=1 empty=1", bus.oMemReq, bus.oEmpty);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.oMemReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_pulse: got req=%0b required 0", bus.oMemReq);
    end
  endtask

  task automatic test_basic_burst();
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 32'h03020100 + 32'(k) * 32'h04040404, 0, 0);
      checks++;
      if (bus.oValidCnt !== 3'(exp_valid()) || bus.oMemReq !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d: got valid=%0d req=%0b required valid=%0d req=0",
                 k, bus.oValidCnt, bus.oMemReq, exp_valid());
      end
    end
    checks++;
    if (bus.oValidCnt !== 3'd6 || bus.oBytes !== 48'h050403020100) begin
      errors++;
      $display("FAIL basic_window: got valid=%0d bytes=%h required 6 / 050403020100", bus.oValidCnt, bus.oBytes);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.oMemReq !== 1'b1) begin
      errors++;
      $display("FAIL basic_rerequest_at_32: got req=%0b required 1", bus.oMemReq);
    end
  endtask

  task automatic test_index();
    int total = 0;
    int v;
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 3, 32'hAABBCCDD, 0, 0);
    checks++;
    if (bus.oBytes[7:0] !== 8'hAA || bus.oValidCnt !== 3'd1) begin
      errors++;
      $display("FAIL index_first_byte: got byte=%h valid=%0d required AA / 1", bus.oBytes[7:0], bus.oValidCnt);
    end
    for (int k = 1; k < 8; k++) cycle(1, 2'($urandom_range(0, 3)), $urandom, 0, 0);
    for (int n = 0; n < 20 && bus.oEmpty !== 1'b1; n++) begin
      v = int'(bus.oValidCnt);
      total += v;
      cycle(0, 0, 0, 0, v);
      checks++;
      if (bus.oBytes !== exp_bytes()) begin
        errors++;
        $display("FAIL index_drain_bytes: got %h required %h", bus.oBytes, exp_bytes());
      end
    end
    checks++;
    if (total != 29 || bus.oEmpty !== 1'b1) begin
      errors++;
      $display("FAIL index_count: got %0d bytes drained empty=%0b required 29 / 1", total, bus.oEmpty);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 2, 32'h11223344, 0, 0);
    cycle(1, 0, 32'h55667788, 0, 0);
    checks++;
    if (bus.oValidCnt !== 3'd6 || bus.oBytes !== 48'h556677881122) begin
      errors++;
      $display("FAIL pushpop_setup: got valid=%0d bytes=%h required 6 / 556677881122", bus.oValidCnt, bus.oBytes);
    end
    cycle(1, 0, 32'h99AABBCC, 0, 6);
    checks++;
    if (bus.oValidCnt !== 3'd4 || bus.oBytes !== 48'h000099AABBCC) begin
      errors++;
      $display("FAIL pushpop_result: got valid=%0d bytes=%h required 4 / 000099aabbcc", bus.oValidCnt, bus.oBytes);
    end
  endtask

  task automatic test_jump_discard();
    logic [31:0] nd [8];
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, $urandom, 0, 0);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (bus.oMemReq !== 1'b1 || bus.oEmpty !== 1'b1 || bus.oValidCnt !== 3'd0) begin
      errors++;
      $display("FAIL jump_flush: got req=%0b empty=%0b valid=%0d required 1/1/0", bus.oMemReq, bus.oEmpty, bus.oValidCnt);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, $urandom, 0, 0);
      checks++;
      if (bus.oEmpty !== 1'b1 || bus.oMemReq !== 1'b0) begin
        errors++;
        $display("FAIL jump_discard%0d: got empty=%0b req=%0b required 1/0", k, bus.oEmpty, bus.oMemReq);
      end
    end
    for (int k = 0; k < 8; k++) begin
      nd[k] = $urandom;
      cycle(1, 0, nd[k], 0, 0);
    end
    checks++;
    if (bus.oValidCnt !== 3'd6 || bus.oBytes !== {nd[1][15:0], nd[0]}) begin
      errors++;
      $display("FAIL jump_new_burst: got valid=%0d bytes=%h required 6 / %h", bus.oValidCnt, bus.oBytes, {nd[1][15:0], nd[0]});
    end
`ifdef PREFETCH_PERF_EN
    checks++;
    if (discard_cnt !== 16'd5 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL jump_perf: got discards=%0d flushes=%0d required 5 / 1", discard_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_fill_stall();
    int n;
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(1, 0, $urandom, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.oMemReq !== 1'b1) begin
      errors++;
      $display("FAIL fill_second_req: got req=%0b required 1", bus.oMemReq);
    end
    for (int k = 0; k < 8; k++) cycle(1, 0, $urandom, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (bus.oMemReq !== 1'b0 || bus.oValidCnt !== 3'd6 || bus.oBytes !== exp_bytes()) begin
        errors++;
        $display("FAIL fill_full_hold%0d: got req=%0b valid=%0d bytes=%h required 0/6/%h",
                 k, bus.oMemReq, bus.oValidCnt, bus.oBytes, exp_bytes());
      end
    end
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0, 0, 6);
      n = k;
      if (bus.oMemReq === 1'b1) break;
    end
    checks++;
    if (n != 7 || bus.oBytes !== exp_bytes()) begin
      errors++;
      $display("FAIL fill_third_req: got request after %0d pops bytes=%h required 7 / %h", n, bus.oBytes, exp_bytes());
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, $urandom, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes} !== 53'd0) begin
      errors++;
      $display("FAIL midreset_async: got req=%0b empty=%0b valid=%0d bytes=%h required all zero",
               bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes);
    end
    bus.iAck32 = 1'b1;
    repeat (2) begin
      bus.iData32 = $urandom;
      @(posedge clk);
    end
    #1;
    bus.iAck32 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.oMemReq !== 1'b1 || bus.oEmpty !== 1'b1 || bus.oValidCnt !== 3'd0) begin
      errors++;
      $display("FAIL midreset_fresh_req: got req=%0b empty=%0b valid=%0d required 1/1/0", bus.oMemReq, bus.oEmpty, bus.oValidCnt);
    end
    for (int k = 0; k < 8; k++) cycle(1, 0, $urandom, 0, 0);
    checks++;
    if (bus.oValidCnt !== 3'd6 || bus.oBytes !== exp_bytes()) begin
      errors++;
      $display("FAIL midreset_refill: got valid=%0d bytes=%h required 6 / %h", bus.oValidCnt, bus.oBytes, exp_bytes());
    end
  endtask

  task automatic test_random();
    int owed = 0;
    bit a, j;
    int c;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      a = (owed > 0) && ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, exp_valid()));
      cycle(a, 2'($urandom_range(0, 3)), $urandom, j, c);
      if (a) owed--;
      if (m_req) owed += 8;
      checks++;
      if ({bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes} !==
          {m_req, m_empty, 3'(exp_valid()), exp_bytes()}) begin
        errors++;
        $display("FAIL random_cycle%0d: got req=%0b empty=%0b valid=%0d bytes=%h required req=%0b empty=%0b valid=%0d bytes=%h",
                 n, bus.oMemReq, bus.oEmpty, bus.oValidCnt, bus.oBytes,
                 m_req, m_empty, exp_valid(), exp_bytes());
      end
    end
`ifdef PREFETCH_PERF_EN
    checks++;
    if (flush_cnt !== 16'(m_flushes) || discard_cnt !== 16'(m_discards)) begin
      errors++;
      $display("FAIL random_perf: got flushes=%0d discards=%0d required %0d / %0d",
               flush_cnt, discard_cnt, m_flushes, m_discards);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_burst();
    test_index();
    test_push_pop_same_cycle();
    test_jump_discard();
    test_fill_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
